// File: rtl/calc_sequencer_pkg.sv
// calc_pkg: shared types and constants for the keypad calculator sequencer.
//   - calc_state_e : sequencer FSM states
//   - REG_A_IDX / REG_B_IDX : register bank slots for operands A and B
//   - OP_ADD/OP_SUB/OP_AND/OP_OR : 2-bit ALU operation codes
//   - DATA_W : operand / result width
package calc_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic [1:0] REG_A_IDX = 2'd0;
  localparam logic [1:0] REG_B_IDX = 2'd1;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_OR  = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_A_HI,
    S_A_LO,
    S_B_HI,
    S_B_LO,
    S_WAIT_OP,
    S_EXEC,
    S_WB,
    S_DONE
  } calc_state_e;

endpackage

// File: rtl/calc_entry_timer.sv
// calc_entry_timer: idle counter for keypad entry.
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : count only while high; counter is held at zero otherwise
//   restart    : synchronous restart to zero (a key arrived / abort)
//   expire     : single-cycle pulse in the LIMIT-th consecutive idle cycle
module calc_entry_timer #(
  parameter logic [23:0] LIMIT = 24'd10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic restart,
  output logic expire
);

  logic [23:0] count_q;

  // count_q holds the number of idle cycles already completed, so the
  // LIMIT-th idle cycle is the one that sees LIMIT-1.
  assign expire = enable && !restart && (count_q == LIMIT - 24'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (!enable || restart || expire) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 24'd1;
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad-driven sequencer for a 4x8 register bank and a
// 2-bit-select ALU. Two hex nibbles build operand A (written to R0), two
// more build B (written to R1); start issues one ALU op whose result is
// written back to DEST_REG.
//
// Optional build macro: CALC_ACCUM_EN -- accumulator mode: the result is
// written to R0 and the FSM returns to B entry after DONE.
//
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   key_valid/key_code : one key per cycle from the keypad encoder
//   op_sel             : ALU op, latched when start is accepted
//   start              : execute, honoured only in WAIT_OP
//   clear              : synchronous abort to IDLE, highest priority
//   alu_out, alu_zero  : combinational ALU result / zero flag
//   addr_a, addr_b     : register bank read addresses
//   addr_wr, wr_data   : register bank write address / data
//   wr_en              : register bank write enable (one-cycle pulse)
//   alu_sel            : ALU operation select
//   busy               : high whenever the FSM is not in IDLE
//   done               : one-cycle pulse after result writeback
//   timeout            : one-cycle pulse on entry abort
//   zero_flag          : ALU zero flag captured at the last writeback
module calc_sequencer
  import calc_pkg::*;
#(
  parameter logic [1:0]  DEST_REG       = 2'd2,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  input  logic [1:0]        op_sel,
  input  logic              start,
  input  logic              clear,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  output logic [1:0]        addr_a,
  output logic [1:0]        addr_b,
  output logic [1:0]        addr_wr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_en,
  output logic [1:0]        alu_sel,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              zero_flag
);

`ifdef CALC_ACCUM_EN
  localparam logic [1:0]  WB_DEST    = REG_A_IDX;
  localparam calc_state_e AFTER_DONE = S_B_HI;
`else
  localparam logic [1:0]  WB_DEST    = DEST_REG;
  localparam calc_state_e AFTER_DONE = S_IDLE;
`endif

  calc_state_e       state_q, state_d;
  logic [3:0]        hi_q, hi_d;
  logic [1:0]        addr_a_d, addr_b_d, addr_wr_d, alu_sel_d;
  logic [DATA_W-1:0] wr_data_d;
  logic              wr_en_d, busy_d, done_d, timeout_d, zero_flag_d;
  logic              entry_active, expire;

  assign entry_active = (state_q == S_A_HI) || (state_q == S_A_LO) ||
                        (state_q == S_B_HI) || (state_q == S_B_LO);

  calc_entry_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (entry_active),
    .restart(key_valid || clear),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      hi_q      <= '0;
      addr_a    <= '0;
      addr_b    <= '0;
      addr_wr   <= '0;
      wr_data   <= '0;
      wr_en     <= 1'b0;
      alu_sel   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      zero_flag <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      addr_a    <= addr_a_d;
      addr_b    <= addr_b_d;
      addr_wr   <= addr_wr_d;
      wr_data   <= wr_data_d;
      wr_en     <= wr_en_d;
      alu_sel   <= alu_sel_d;
      busy      <= busy_d;
      done      <= done_d;
      timeout   <= timeout_d;
      zero_flag <= zero_flag_d;
    end
  end

  // Outputs are registered: each branch sets the value the output must carry
  // in the cycle after the transition (e.g. EXEC addresses are set on the
  // edge entering EXEC, WB write data is alu_out sampled at the end of EXEC).
  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    addr_a_d    = addr_a;
    addr_b_d    = addr_b;
    addr_wr_d   = addr_wr;
    wr_data_d   = wr_data;
    alu_sel_d   = alu_sel;
    zero_flag_d = zero_flag;
    wr_en_d     = 1'b0;
    done_d      = 1'b0;
    timeout_d   = 1'b0;

    if (clear) begin
      state_d = S_IDLE;
    end else if (expire) begin
      state_d   = S_IDLE;
      timeout_d = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE, S_A_HI: begin
          if (key_valid) begin
            hi_d    = key_code;
            state_d = S_A_LO;
          end
        end
        S_A_LO: begin
          if (key_valid) begin
            wr_en_d   = 1'b1;
            addr_wr_d = REG_A_IDX;
            wr_data_d = {hi_q, key_code};
            state_d   = S_B_HI;
          end
        end
        S_B_HI: begin
          if (key_valid) begin
            hi_d    = key_code;
            state_d = S_B_LO;
          end
        end
        S_B_LO: begin
          if (key_valid) begin
            wr_en_d   = 1'b1;
            addr_wr_d = REG_B_IDX;
            wr_data_d = {hi_q, key_code};
            state_d   = S_WAIT_OP;
          end
        end
        S_WAIT_OP: begin
          if (start) begin
            alu_sel_d = op_sel;
            addr_a_d  = REG_A_IDX;
            addr_b_d  = REG_B_IDX;
            state_d   = S_EXEC;
          end
        end
        S_EXEC: begin
          wr_en_d     = 1'b1;
          addr_wr_d   = WB_DEST;
          wr_data_d   = alu_out;
          zero_flag_d = alu_zero;
          state_d     = S_WB;
        end
        S_WB: begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
        S_DONE: begin
          state_d = AFTER_DONE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Keypad-driven controller that sequences the 4x8-bit register bank and the 2-bit-select ALU. It assembles two 8-bit operands from hex keypad nibbles, writes them to R0/R1, issues one ALU operation on start, and writes the result back to a destination register. It sits between the keypad encoder (key_p/hex_out) and the register bank and ALU, and replaces direct pin control of the addresses, EN and OP.

Parameters:
DEST_REG, 2'd2, register index that receives the ALU result
TIMEOUT_CYCLES, 24'd10_000_000, idle clocks allowed between keys during entry before abort

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
key_valid  in  1  one-cycle pulse from the encoder: key pressed
key_code  in  4  hex nibble from the encoder, valid with key_valid
op_sel  in  2  ALU operation, sampled on the accepted start
start  in  1  level/pulse: execute, accepted only in WAIT_OP
clear  in  1  synchronous abort to IDLE
alu_out  in  8  combinational ALU result
alu_zero  in  1  combinational ALU zero flag
addr_a  out  2  register bank read port A address
addr_b  out  2  register bank read port B address
addr_wr  out  2  register bank write address
wr_data  out  8  register bank write data
wr_en  out  1  register bank write enable, one-cycle pulse
alu_sel  out  2  ALU operation select
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after result writeback
timeout  out  1  one-cycle pulse on entry abort
zero_flag  out  1  latched ALU zero flag from the last writeback

Behaviour:
- All outputs are registered. Reset values: addresses 0, wr_data 0, wr_en 0, alu_sel 0, busy 0, done 0, timeout 0, zero_flag 0. The FSM resets to IDLE.
- FSM states: IDLE, A_HI, A_LO, B_HI, B_LO, WAIT_OP, EXEC, WB, DONE.
- IDLE: key_valid captures the high nibble of A and moves to A_LO. A_HI exists only for the optional mode.
- A_LO: key_valid forms A = {hi, key}. In the next cycle wr_en=1, addr_wr=0, wr_data=A. Then B_HI.
- B_HI: key_valid captures the high nibble of B and moves to B_LO.
- B_LO: key_valid forms B = {hi, key}. In the next cycle wr_en=1, addr_wr=1, wr_data=B. Then WAIT_OP.
- WAIT_OP: key_valid is ignored. start latches op_sel and moves to EXEC.
- EXEC (1 cycle): addr_a=0, addr_b=1, alu_sel=latched op. alu_out and alu_zero are sampled at the end of this cycle.
- WB (1 cycle): wr_en=1, addr_wr=DEST_REG, wr_data=sampled alu_out. zero_flag is updated from the sampled alu_zero.
- DONE (1 cycle): done=1, then IDLE.
- Latency: start accepted at edge N; EXEC cycle N+1; WB cycle N+2; done cycle N+3.
- Timeout: an entry-idle counter runs in A_HI, A_LO, B_HI and B_LO and resets on every key_valid. When it reaches TIMEOUT_CYCLES-1: timeout pulses, FSM goes to IDLE, no write is issued. A write already scheduled (wr_en in flight) still completes.
- clear has the highest priority in every state. Next state is IDLE, no wr_en is issued, done and timeout are not asserted, and zero_flag is held.
- clear and key_valid in the same cycle: clear wins and the key is dropped.
- start and clear in the same cycle: clear wins.
- key_valid held high for multiple cycles counts as one key per cycle. Edge detection is the encoder's job.
- Reset mid-operation (rst_n low) clears everything asynchronously. A pending write is lost.
- wr_en is never asserted in two consecutive cycles.

Optional Feature:
CALC_ACCUM_EN.
- When defined: accumulator mode. WB always writes to R0, ignoring DEST_REG. After DONE the FSM goes to B_HI, so chained operations only need a new B. IDLE is re-entered only on clear or timeout. From IDLE, the first key enters A_HI semantics through the normal A path.
- When undefined: behaviour is exactly as above, with WB writing to DEST_REG and DONE going to IDLE.

Decomposition:
- Package calc_pkg holds: state enum; register index constants REG_A_IDX=0, REG_B_IDX=1; op codes OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3; data width constant 8.
- One natural sub-module, calc_entry_timer: a 24-bit counter with restart and enable inputs and a single-cycle expire output.

Test Plan:
- Keys 3,C,0,5, then start with op_sel=OP_ADD -> R0 write 8'h3C, R1 write 8'h05, WB writes 8'h41 to R2, done 3 cycles after start, zero_flag=0.
- Keys 0,7,0,7, start with OP_SUB -> WB wr_data 8'h00, zero_flag=1, busy drops the cycle after done.
- Key 1, then no key for TIMEOUT_CYCLES (use parameter 16) -> timeout pulses at exactly 16 idle cycles, no wr_en, FSM back in IDLE.
- Enter A and B, assert clear in WAIT_OP together with start -> no EXEC, no WB, done=0, busy=0 next cycle.
- Assert rst_n low during WB -> all outputs 0 immediately; next key sequence works normally.
- CALC_ACCUM_EN defined: A=8'h10, B=8'h01 ADD -> R0=8'h11; then B=8'h02 ADD -> R0=8'h13 with no A re-entry.
